// File: rtl/kt_mon_pkg.sv
// Shared types for the Knight's Tour bench monitors: watchdog modes and channel states.
package kt_mon_pkg;

  typedef enum logic [1:0] {
    WD_CHANGE = 2'b00,
    WD_FALL   = 2'b01,
    WD_RISE   = 2'b10,
    WD_EQUAL  = 2'b11
  } wd_mode_t;

  typedef enum logic {
    WD_IDLE = 1'b0,
    WD_WAIT = 1'b1
  } wd_state_t;

endpackage

// File: rtl/event_watch_ch.sv
// Single watchdog channel: arm/disarm FSM, timeout counter, baseline capture and hit direction.
module event_watch_ch
  import kt_mon_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int TMR_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             disarm,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] sample,
  input  logic [TMR_W-1:0] timeout,
  output logic             busy,
  output logic             done,
  output logic             tmo,
  output logic             dir_up
);

  wd_state_t        state, state_nxt;
  wd_mode_t         mode_r;
  logic [WIDTH-1:0] base, tgt;
  logic [TMR_W-1:0] cnt, limit;
  logic             prev0;
  logic             hit, expire, done_nxt, tmo_nxt;

  always_comb begin
    hit       = 1'b0;
    expire    = 1'b0;
    state_nxt = state;
    done_nxt  = 1'b0;
    tmo_nxt   = 1'b0;
    case (mode_r)
      WD_CHANGE: hit = (sample != base);
      WD_FALL:   hit = prev0 & ~sample[0];
      WD_RISE:   hit = ~prev0 & sample[0];
      default:   hit = (sample == tgt);
    endcase
    // cnt holds the number of evaluated edges before this one
    expire = (limit != '0) && (cnt == limit - TMR_W'(1));
    if (disarm) begin
      state_nxt = WD_IDLE;
    end else if (arm) begin
      state_nxt = WD_WAIT;
    end else if (state == WD_WAIT) begin
      if (hit) begin
        state_nxt = WD_IDLE;
        done_nxt  = 1'b1;
      end else if (expire) begin
        state_nxt = WD_IDLE;
        tmo_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WD_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r <= WD_CHANGE;
      base   <= '0;
      tgt    <= '0;
      cnt    <= '0;
      limit  <= '0;
      prev0  <= 1'b0;
      done   <= 1'b0;
      tmo    <= 1'b0;
      dir_up <= 1'b0;
    end else begin
      done <= done_nxt;
      tmo  <= tmo_nxt;
      if (arm && !disarm) begin
        mode_r <= wd_mode_t'(mode);
        tgt    <= target;
        limit  <= timeout;
        base   <= sample;
        prev0  <= sample[0];
        cnt    <= '0;
      end else if (state == WD_WAIT) begin
        prev0 <= sample[0];
        if (cnt != '1) cnt <= cnt + TMR_W'(1);
        if (done_nxt) dir_up <= ($signed(sample) > $signed(base));
      end
    end
  end

  assign busy = (state == WD_WAIT);

endmodule

// File: rtl/event_watchdog.sv
// Multi-channel event watchdog: NUM_CH independent channels plus a sticky error flag
// and the index of the first channel to time out.
module event_watchdog
  import kt_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 17,
  parameter int TMR_W  = 22
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          arm,
  input  logic [NUM_CH-1:0]          disarm,
  input  logic [2*NUM_CH-1:0]        mode,
  input  logic [WIDTH*NUM_CH-1:0]    target,
  input  logic [WIDTH*NUM_CH-1:0]    sample,
  input  logic [TMR_W-1:0]           timeout,
  input  logic                       clr_err,
  output logic [NUM_CH-1:0]          busy,
  output logic [NUM_CH-1:0]          done,
  output logic [NUM_CH-1:0]          tmo,
  output logic [NUM_CH-1:0]          dir_up,
  output logic                       err,
  output logic [$clog2(NUM_CH)-1:0]  first_tmo
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0] tmo_idx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    event_watch_ch #(
      .WIDTH (WIDTH),
      .TMR_W (TMR_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .arm     (arm[g]),
      .disarm  (disarm[g]),
      .mode    (mode[2*g +: 2]),
      .target  (target[WIDTH*g +: WIDTH]),
      .sample  (sample[WIDTH*g +: WIDTH]),
      .timeout (timeout),
      .busy    (busy[g]),
      .done    (done[g]),
      .tmo     (tmo[g]),
      .dir_up  (dir_up[g])
    );
  end

  // lowest index wins when several channels time out together
  always_comb begin
    tmo_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (tmo[i]) tmo_idx = IDX_W'(i);
  end

  // a new timeout beats a simultaneous clear and re-captures the index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      first_tmo <= '0;
    end else if (|tmo) begin
      if (!err || clr_err) first_tmo <= tmo_idx;
      err <= 1'b1;
    end else if (clr_err) begin
      err       <= 1'b0;
      first_tmo <= '0;
    end
  end

endmodule
